// File: rtl/sdram_port_arbiter_pkg.sv
// sdram_arb_pkg
//   Shared definitions for the SDRAM port arbiter slice: the transaction
//   state encoding, default geometry (port count, address and data widths)
//   and the arbitration mode selectors.
//   No ports; imported by the interface, the arbiter core and the top.
package sdram_arb_pkg;

  // IDLE waits for a request, XFER holds RD/WR until the controller
  // answers, ACK is the single completion cycle seen by the winning port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  localparam int DEF_NPORTS = 4;
  localparam int DEF_AW     = 22;
  localparam int DEF_DW     = 16;

  // Arbitration modes: lowest index always wins, or rotate from the
  // port after the last grant.
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if
//   Bundles the per-port request/acknowledge signals and the single-word
//   SDRAM controller signals that the arbiter sits between.
//   Ports (as interface members):
//     iREQ/iWE/iADDR/iWDATA   requester side, one lane per port
//     oACK/oRDATA/oBUSY/oGNT  completion, read-data bank, status
//     oSDR_ADDR/oSDR_WDATA/oSDR_RD/oSDR_WR  command to the controller
//     iSDR_RDATA/iSDR_DONE    response from the controller
//   Modports:
//     master  the environment (clients plus controller) driving the arbiter
//     slave   the arbiter itself
interface sdram_port_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS = DEF_NPORTS,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW
);

  logic [NPORTS-1:0]    iREQ;
  logic [NPORTS-1:0]    iWE;
  logic [NPORTS*AW-1:0] iADDR;
  logic [NPORTS*DW-1:0] iWDATA;
  logic [NPORTS-1:0]    oACK;
  logic [NPORTS*DW-1:0] oRDATA;
  logic                 oBUSY;
  logic [NPORTS-1:0]    oGNT;
  logic [AW-1:0]        oSDR_ADDR;
  logic [DW-1:0]        oSDR_WDATA;
  logic                 oSDR_RD;
  logic                 oSDR_WR;
  logic [DW-1:0]        iSDR_RDATA;
  logic                 iSDR_DONE;

  modport master (
    output iREQ, iWE, iADDR, iWDATA, iSDR_RDATA, iSDR_DONE,
    input  oACK, oRDATA, oBUSY, oGNT, oSDR_ADDR, oSDR_WDATA, oSDR_RD, oSDR_WR
  );

  modport slave (
    input  iREQ, iWE, iADDR, iWDATA, iSDR_RDATA, iSDR_DONE,
    output oACK, oRDATA, oBUSY, oGNT, oSDR_ADDR, oSDR_WDATA, oSDR_RD, oSDR_WR
  );

endinterface

// File: rtl/sdram_port_arbiter_rr.sv
// rr_arbiter
//   Combinational winner selection. Produces a one-hot grant from the
//   request vector. In fixed mode the search starts at port 0, so the
//   lowest active index wins. In round-robin mode the search starts at
//   ptr and wraps, so the first active port at or after ptr wins.
//   Ports:
//     req  in   per-port request levels
//     ptr  in   round-robin start index (ignored in fixed mode)
//     gnt  out  one-hot winner, all zero when nothing is requested
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS   = DEF_NPORTS,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic [NPORTS-1:0]         req,
  input  logic [$clog2(NPORTS)-1:0] ptr,
  output logic [NPORTS-1:0]         gnt
);

  localparam int PW = $clog2(NPORTS);

  // Walk the ports once starting at the chosen origin; the index wraps
  // explicitly so non-power-of-two port counts never reach unused codes.
  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    gnt   = '0;
    found = 1'b0;
    idx   = (ARB_MODE == ARB_FIXED) ? '0 : ptr;
    for (int k = 0; k < NPORTS; k++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      idx = (idx == PW'(NPORTS - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares one single-word SDRAM controller (RD/WR held until DONE) among
//   NPORTS requesters with a request/acknowledge handshake per port.
//   Each transaction latches the winner's command, holds RD or WR until
//   the controller reports DONE, then pulses the winner's ACK for one
//   cycle. Read data is kept per port in a holding register bank.
//   Ports:
//     iCLK  in  system clock, rising edge
//     iRST  in  synchronous active-high reset
//     bus   sdram_port_arbiter_if.slave: requester lanes, status and the
//           controller command/response signals
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS   = DEF_NPORTS,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int ARB_MODE = ARB_RR
) (
  input logic                 iCLK,
  input logic                 iRST,
  sdram_port_arbiter_if.slave bus
);

  localparam int PW = $clog2(NPORTS);

  arb_state_e           state_q, state_d;
  logic [NPORTS-1:0]    gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [NPORTS-1:0]    ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic [NPORTS*DW-1:0] rdata_q, rdata_d;
  logic [PW-1:0]        ptr_q, ptr_d;

  logic [NPORTS-1:0]    win_gnt;
  logic [PW-1:0]        win_idx;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;
  logic                 sel_we;

  rr_arbiter #(
    .NPORTS   (NPORTS),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req (bus.iREQ),
    .ptr (ptr_q),
    .gnt (win_gnt)
  );

  // Steer the winning port's command lane; the one-hot grant guarantees
  // at most one lane is picked.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    win_idx   = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (win_gnt[p]) begin
        sel_addr  = bus.iADDR[p*AW +: AW];
        sel_wdata = bus.iWDATA[p*DW +: DW];
        sel_we    = bus.iWE[p];
        win_idx   = PW'(p);
      end
    end
  end

  // Transaction sequencing. Only the latched command regs feed the
  // controller, so other ports' inputs cannot disturb a transfer. DONE
  // is only looked at in XFER, so a stray DONE elsewhere is harmless.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack_d   = '0;
    busy_d  = busy_q;
    rdata_d = rdata_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|bus.iREQ) begin
          gnt_d   = win_gnt;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          rd_d    = ~sel_we;
          wr_d    = sel_we;
          busy_d  = 1'b1;
          ptr_d   = (win_idx == PW'(NPORTS - 1)) ? '0 : win_idx + 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        if (bus.iSDR_DONE) begin
          rd_d  = 1'b0;
          wr_d  = 1'b0;
          ack_d = gnt_q;
          if (!we_q) begin
            for (int p = 0; p < NPORTS; p++) begin
              if (gnt_q[p]) begin
                rdata_d[p*DW +: DW] = bus.iSDR_RDATA;
              end
            end
          end
          state_d = ACK;
        end
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs register here; reset clears everything,
  // including a transfer that is in flight.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.oACK       = ack_q;
  assign bus.oRDATA     = rdata_q;
  assign bus.oBUSY      = busy_q;
  assign bus.oGNT       = gnt_q;
  assign bus.oSDR_ADDR  = addr_q;
  assign bus.oSDR_WDATA = wdata_q;
  assign bus.oSDR_RD    = rd_q;
  assign bus.oSDR_WR    = wr_q;

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Parametrised N-port arbiter that shares one single-word SDRAM controller (RD/WR-held-until-DONE interface) among NPORTS independent requesters. It replaces the fixed four-way select-driven multiplexer with a request/acknowledge handshake per port and hardware arbitration in fixed-priority or round-robin mode. Sits between the client logic (USB host, display, capture paths) and the SDRAM controller instance.

## Interface
- NPORTS, 4: number of requester ports (2..8)
- AW, 22: word address width
- DW, 16: data width
- ARB_MODE, 1: 0 = fixed priority (lowest index wins), 1 = round-robin
- iCLK  in  1  system clock, all logic on rising edge
- iRST  in  1  reset, synchronous, active-high
- iREQ  in  NPORTS  per-port request level
- iWE  in  NPORTS  per-port 1 = write, 0 = read
- iADDR  in  NPORTS*AW  port p address at [p*AW +: AW]
- iWDATA  in  NPORTS*DW  port p write data at [p*DW +: DW]
- oACK  out  NPORTS  one-cycle completion pulse per port
- oRDATA  out  NPORTS*DW  per-port read-data holding register
- oBUSY  out  1  transaction in flight
- oGNT  out  NPORTS  one-hot current/last grant
- oSDR_ADDR  out  AW  to controller ADDR
- oSDR_WDATA  out  DW  to controller DATAIN
- oSDR_RD  out  1  to controller RD
- oSDR_WR  out  1  to controller WR
- iSDR_RDATA  in  DW  from controller DATAOUT
- iSDR_DONE  in  1  from controller DONE

## Operation
- FSM states: IDLE, XFER, ACK.
- IDLE: if any iREQ set, pick winner g; register g, iADDR[g], iWDATA[g], iWE[g] into command regs; -> XFER. No request: stay.
- XFER: oSDR_RD = ~we_r, oSDR_WR = we_r, held high every cycle until iSDR_DONE sampled 1; on that edge drop RD/WR, if read load oRDATA[g] <= iSDR_RDATA, -> ACK.
- ACK: oACK[g] = 1 for exactly this cycle; -> IDLE. IDLE then re-arbitrates.
- Requester rule: hold iREQ, iWE, iADDR, iWDATA stable from assertion until oACK seen; drop iREQ on the edge ending the ACK cycle or issue next request. Changes to non-granted ports' inputs never disturb the transaction in flight.
- Fixed priority: lowest-index active request wins.
- Round-robin: pointer = (last grant + 1) mod NPORTS; first active request at or after pointer wins with wrap. Pointer updates only on grant.
- oRDATA[p] changes only on completion of a read by port p; writes never alter it.
- Simultaneous requests: exactly one granted per IDLE cycle; the others wait, never dropped.
- iSDR_DONE outside XFER ignored.
- Reset (at any time, including mid-XFER): state IDLE, oSDR_RD/oSDR_WR 0, oACK 0, oBUSY 0, oGNT 0, oRDATA all 0, command regs 0, RR pointer 0. The controller is reset by the same iRST.

## Timing
- All outputs registered. Reset values: every output 0.
- Request high before edge E0 in IDLE -> oSDR_RD/WR high from E0 -> DONE sampled at edge Ek -> oACK high for cycle after Ek -> IDLE at Ek+1.
- Min turnaround per transaction: controller latency + 2 cycles (XFER exit, ACK).
- oBUSY = 1 in XFER and ACK.
- oGNT updates at grant edge and holds until next grant.
- Starvation bound, round-robin: a held request is granted within NPORTS-1 other transactions.

## Structure
- Package sdram_arb_pkg: state enum (IDLE, XFER, ACK), NPORTS/AW/DW defaults, ARB_MODE constants.
- Sub-module rr_arbiter: combinational one-hot winner from req vector, pointer and mode; FSM, command regs and read-data bank stay in the top.

## Test plan
- Single read: port 2 reads 0x00_1234, controller model DONE after 5 cycles returning 0xBEEF -> oSDR_RD high 5 cycles, oACK[2] one pulse, oRDATA[2] = 0xBEEF, other oRDATA 0.
- Write then read-back: port 0 writes 0xA5A5 to 0x10, port 1 reads 0x10 -> oRDATA[1] = 0xA5A5, oRDATA[0] unchanged.
- All four ports request continuously, ARB_MODE=1 -> grant order 0,1,2,3,0,...; ARB_MODE=0 -> port 0 granted every transaction, others never until port 0 drops.
- Port 3 requests while port 1 in XFER and port 1 changes iADDR mid-flight of port 3's grant -> only granted port's latched address driven on oSDR_ADDR.
- iRST asserted two cycles into XFER -> next cycle oSDR_RD/WR 0, oBUSY 0, no oACK; after release, pending request re-granted from pointer 0.
- Spurious iSDR_DONE in IDLE -> no oACK, no oRDATA change.
